pe_share_arbiter: RTL and testbench

// - Shares one PE serializer unit among NUM_REQS requesters (e.g. per-warp issue slots feeding one FPU/ALU cluster).
// - Round-robin grant on the request side; requester index is appended to the tag so responses demux back without lookup.
// - Caps in-flight operations with a credit counter so the unit's internal pipeline never backs up into the arbiter.

---
 rtl/pe_share_arbiter.sv | 133 +++++++++++++
 tb/tb_pe_share_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_share_arbiter.sv
// Shares one PE serializer among NUM_REQS requesters: round-robin issue with stall lock,
// credit-capped in-flight count, and tag-indexed response demux. Optional macro: PE_ARB_PRIORITY_EN.
module pe_share_arbiter #(
  parameter int NUM_REQS       = 4,
  parameter int NUM_LANES      = 4,
  parameter int DATA_IN_WIDTH  = 32,
  parameter int DATA_OUT_WIDTH = 32,
  parameter int TAG_WIDTH      = 8,
  parameter int MAX_PENDING    = 8,
  localparam int REQW = $clog2(NUM_REQS),
  localparam int DIW  = NUM_LANES * DATA_IN_WIDTH,
  localparam int DOW  = NUM_LANES * DATA_OUT_WIDTH,
  localparam int UTW  = TAG_WIDTH + REQW
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQS-1:0]           req_valid_in,
  input  logic [NUM_REQS*DIW-1:0]       req_data_in,
  input  logic [NUM_REQS*TAG_WIDTH-1:0] req_tag_in,
`ifdef PE_ARB_PRIORITY_EN
  input  logic [NUM_REQS-1:0]           req_prio_in,
`endif
  output logic [NUM_REQS-1:0]           req_ready_in,
  output logic                          unit_valid_out,
  output logic [DIW-1:0]                unit_data_out,
  output logic [UTW-1:0]                unit_tag_out,
  input  logic                          unit_ready_out,
  input  logic                          unit_valid_in,
  input  logic [DOW-1:0]                unit_data_in,
  input  logic [UTW-1:0]                unit_tag_in,
  output logic                          unit_ready_in,
  output logic [NUM_REQS-1:0]           rsp_valid_out,
  output logic [DOW-1:0]                rsp_data_out,
  output logic [TAG_WIDTH-1:0]          rsp_tag_out,
  input  logic [NUM_REQS-1:0]           rsp_ready_out,
  output logic [31:0]                   perf_stall_cycles
);

  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [REQW-1:0] rr_ptr, lock_idx, rr_grant, grant_idx, rsp_idx;
  logic            lock, credit_ok, any_valid, idx_ok, iss_fire, res_fire;
  logic [PW-1:0]   pending;
`ifdef PE_ARB_PRIORITY_EN
  logic [NUM_REQS-1:0] prio_mask;
`endif

  // First set bit of mask at or after start, wrapping; returns start when mask is empty.
  function automatic logic [REQW-1:0] rr_pick(input logic [NUM_REQS-1:0] mask,
                                              input logic [REQW-1:0]     start);
    int idx;
    rr_pick = start;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % NUM_REQS;
      if (mask[idx]) rr_pick = REQW'(idx);
    end
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    any_valid = |req_valid_in;
`ifdef PE_ARB_PRIORITY_EN
    prio_mask = req_valid_in & req_prio_in;
    rr_grant  = (|prio_mask) ? rr_pick(prio_mask, rr_ptr) : rr_pick(req_valid_in, rr_ptr);
`else
    rr_grant  = rr_pick(req_valid_in, rr_ptr);
`endif
    grant_idx = lock ? lock_idx : rr_grant;
    credit_ok = pending < PW'(MAX_PENDING);

    unit_valid_out = reset_n & req_valid_in[grant_idx] & credit_ok;
    unit_data_out  = req_data_in[int'(grant_idx)*DIW +: DIW];
    unit_tag_out   = {grant_idx, req_tag_in[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH]};
    req_ready_in   = '0;
    for (int i = 0; i < NUM_REQS; i++)
      req_ready_in[i] = reset_n & (grant_idx == REQW'(i)) & credit_ok & unit_ready_out;

    // Results route by the index carried in the tag MSBs; an impossible index is sunk.
    rsp_idx       = unit_tag_in[UTW-1:TAG_WIDTH];
    idx_ok        = {1'b0, rsp_idx} < (REQW+1)'(NUM_REQS);
    rsp_data_out  = unit_data_in;
    rsp_tag_out   = unit_tag_in[TAG_WIDTH-1:0];
    rsp_valid_out = '0;
    unit_ready_in = 1'b0;
    if (reset_n) begin
      if (idx_ok) begin
        rsp_valid_out[rsp_idx] = unit_valid_in;
        unit_ready_in          = rsp_ready_out[rsp_idx];
      end else begin
        unit_ready_in = 1'b1;
      end
    end

    iss_fire = unit_valid_out & unit_ready_out;
    res_fire = unit_valid_in & unit_ready_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr            <= '0;
      lock              <= 1'b0;
      lock_idx          <= '0;
      pending           <= '0;
      perf_stall_cycles <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (iss_fire)
        rr_ptr <= (grant_idx == REQW'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
      // A presented-but-refused request pins the grant until it fires.
      lock     <= unit_valid_out & ~unit_ready_out;
      lock_idx <= grant_idx;
      case ({iss_fire, res_fire})
        2'b10:   pending <= pending + PW'(1);
        2'b01:   pending <= pending - PW'(1);
        default: pending <= pending;
      endcase
      if (any_valid && !credit_ok && perf_stall_cycles != '1)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (reset_n) begin
      assert (!(res_fire && !iss_fire && pending == '0))
        else $error("pe_share_arbiter: result returned with nothing pending");
      assert (!(unit_valid_in && !idx_ok))
        else $error("pe_share_arbiter: result tag index out of range");
    end
  end
`endif

endmodule

// File: tb/tb_pe_share_arbiter.sv
// Bench for pe_share_arbiter: directed reset/fairness/lock/credit/demux steps, then random
// traffic, all checked each cycle against a queue-based behavioural model.
module tb_pe_share_arbiter;
  localparam int N = 4, L = 4, DW = 32, TW = 8, MAXP = 2;
  localparam int REQW = 2, UTW = TW + REQW, DIW = L * DW;

  logic clk = 1'b0, reset_n = 1'b1;
  logic [N-1:0]    req_valid_in, req_ready_in, rsp_valid_out, rsp_ready_out;
  logic [N*DIW-1:0] req_data_in;
  logic [N*TW-1:0] req_tag_in;
  logic            unit_valid_out, unit_ready_out, unit_valid_in, unit_ready_in;
  logic [DIW-1:0]  unit_data_out, unit_data_in, rsp_data_out;
  logic [UTW-1:0]  unit_tag_out, unit_tag_in;
  logic [TW-1:0]   rsp_tag_out;
  logic [31:0]     perf_stall_cycles;

  int checks = 0, errors = 0;
  int m_ptr, m_pending, m_lock, m_lock_idx;
  longint m_perf;
  logic [UTW-1:0] inflight[$];
  logic [N-1:0]   last_acc;

  always #5 clk = ~clk;

  pe_share_arbiter #(.NUM_REQS(N), .NUM_LANES(L), .DATA_IN_WIDTH(DW), .DATA_OUT_WIDTH(DW),
                     .TAG_WIDTH(TW), .MAX_PENDING(MAXP)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_in(req_valid_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
    .req_ready_in(req_ready_in),
    .unit_valid_out(unit_valid_out), .unit_data_out(unit_data_out), .unit_tag_out(unit_tag_out),
    .unit_ready_out(unit_ready_out),
    .unit_valid_in(unit_valid_in), .unit_data_in(unit_data_in), .unit_tag_in(unit_tag_in),
    .unit_ready_in(unit_ready_in),
    .rsp_valid_out(rsp_valid_out), .rsp_data_out(rsp_data_out), .rsp_tag_out(rsp_tag_out),
    .rsp_ready_out(rsp_ready_out), .perf_stall_cycles(perf_stall_cycles)
  );

  task automatic check(input string tag, input logic [DIW-1:0] obs, input logic [DIW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Compare all outputs against the model, then advance the model and the clock.
  task automatic step();
    int g, ri;
    bit any, ev, iss, res;
    logic [UTW-1:0] etag;
    #1;
    any = |req_valid_in;
    if (!reset_n) begin
      check("rst_req_ready", req_ready_in, '0);
      check("rst_unit_valid", unit_valid_out, 0);
      check("rst_unit_ready", unit_ready_in, 0);
      check("rst_rsp_valid", rsp_valid_out, '0);
      check("rst_perf", perf_stall_cycles, 0);
      m_ptr = 0; m_pending = 0; m_lock = 0; m_lock_idx = 0; m_perf = 0;
      inflight.delete(); last_acc = '0;
    end else begin
      g = m_ptr;
      if (m_lock != 0) g = m_lock_idx;
      else
        for (int k = 0; k < N; k++)
          if (req_valid_in[(m_ptr + k) % N]) begin g = (m_ptr + k) % N; break; end
      ev = any && (m_pending < MAXP);
      etag = {REQW'(g), req_tag_in[g*TW +: TW]};
      check("unit_valid_out", unit_valid_out, ev);
      if (any) check("req_ready_in", req_ready_in, (m_pending < MAXP && unit_ready_out) ? (1 << g) : 0);
      if (ev) begin
        check("unit_tag_out", unit_tag_out, etag);
        check("unit_data_out", unit_data_out, req_data_in[g*DIW +: DIW]);
      end
      ri = int'(unit_tag_in[UTW-1:TW]);
      check("rsp_valid_out", rsp_valid_out, unit_valid_in ? (1 << ri) : 0);
      check("unit_ready_in", unit_ready_in, rsp_ready_out[ri]);
      check("rsp_tag_out", rsp_tag_out, unit_tag_in[TW-1:0]);
      check("rsp_data_out", rsp_data_out, unit_data_in);
      check("perf_stall", perf_stall_cycles, m_perf[31:0]);
      iss = ev && unit_ready_out;
      res = unit_valid_in && rsp_ready_out[ri];
      last_acc = iss ? N'(1 << g) : '0;
      if (iss) begin m_ptr = (g + 1) % N; inflight.push_back(etag); end
      if (res && inflight.size() > 0) void'(inflight.pop_front());
      m_lock = (ev && !unit_ready_out) ? 1 : 0;
      m_lock_idx = g;
      if (any && m_pending == MAXP && m_perf < 64'hFFFF_FFFF) m_perf++;
      m_pending = m_pending + int'(iss) - int'(res);
    end
    @(posedge clk); #1;
  endtask

  // Return every outstanding result with no new requests.
  task automatic drain();
    req_valid_in = '0;
    for (int k = 0; k < 16 && inflight.size() > 0; k++) begin
      unit_valid_in = 1'b1;
      unit_tag_in   = inflight[0];
      step();
    end
    unit_valid_in = 1'b0;
    check("drain_done", inflight.size(), 0);
  endtask

  task automatic new_req(input int i);
    for (int l = 0; l < L; l++) req_data_in[i*DIW + l*DW +: DW] = $urandom;
    req_tag_in[i*TW +: TW] = TW'($urandom);
  endtask

  initial begin
    for (int i = 0; i < N; i++) new_req(i);
    req_valid_in = '1; unit_ready_out = 1'b1; unit_valid_in = 1'b1;
    unit_tag_in = '0; unit_data_in = {4{32'hC0FFEE11}}; rsp_ready_out = '1;
    #1 reset_n = 1'b0;
    repeat (3) step();

    // Fairness: every requester valid, the unit returns one result per cycle.
    reset_n = 1'b1;
    unit_valid_in = 1'b0;
    for (int c = 0; c < 8; c++) begin
      unit_valid_in = inflight.size() > 0;
      if (inflight.size() > 0) unit_tag_in = inflight[0];
      #1;
      check("fair_grant", unit_tag_out[UTW-1:TW], c % 4);
      check("fair_ready", req_ready_in, 1 << (c % 4));
      step();
    end
    drain();

    // Stall lock: requester 2 refused for 5 cycles while requester 0 joins.
    req_valid_in = 4'b0100; unit_ready_out = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c == 1) req_valid_in[0] = 1'b1;
      #1;
      check("lock_grant", unit_tag_out[UTW-1:TW], 2);
      check("lock_data", unit_data_out, req_data_in[2*DIW +: DIW]);
      check("lock_ready", req_ready_in, '0);
      step();
    end
    unit_ready_out = 1'b1;
    #1;
    check("lock_fire_grant", unit_tag_out[UTW-1:TW], 2);
    check("lock_fire_ready", req_ready_in, 4'b0100);
    step();
    req_valid_in[2] = 1'b0;
    #1;
    check("post_lock_grant", unit_tag_out[UTW-1:TW], 0);
    step();
    drain();

    // Credits: two issues fill the window, then stall while perf counts.
    req_valid_in = 4'b0010;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("credit_valid", unit_valid_out, c < 2);
      if (c >= 2) begin
        check("credit_ready", req_ready_in, '0);
        check("credit_perf", perf_stall_cycles, c - 2);
      end
      step();
    end
    unit_valid_in = 1'b1; unit_tag_in = inflight[0];
    #1;
    check("simul_no_issue", unit_valid_out, 0);
    step();
    unit_valid_in = 1'b0;
    #1;
    check("after_result_issue", unit_valid_out, 1);
    step();
    #1;
    check("refilled_stall", unit_valid_out, 0);
    step();

    // Response demux to requester 3 held by its ready.
    req_valid_in = '0;
    unit_valid_in = 1'b1; unit_tag_in = {2'd3, 8'hA5}; rsp_ready_out = 4'b0111;
    for (int c = 0; c < 2; c++) begin
      #1;
      check("demux_valid", rsp_valid_out, 4'b1000);
      check("demux_tag", rsp_tag_out, 8'hA5);
      check("demux_hold", unit_ready_in, 0);
      step();
    end
    rsp_ready_out = 4'b1000;
    #1;
    check("demux_accept", unit_ready_in, 1);
    step();
    unit_valid_in = 1'b0; rsp_ready_out = '1;
    #1;
    check("demux_idle", rsp_valid_out, '0);
    step();
    drain();

    // Random traffic: requesters hold valid and data until accepted.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if (!(req_valid_in[i] && !last_acc[i])) begin
          req_valid_in[i] = ($urandom % 3) != 0;
          new_req(i);
        end
      unit_ready_out = ($urandom % 4) != 0;
      if (inflight.size() > 0 && ($urandom % 2) != 0) begin
        unit_valid_in = 1'b1; unit_tag_in = inflight[0];
      end else begin
        unit_valid_in = 1'b0; unit_tag_in = UTW'($urandom);
      end
      for (int l = 0; l < L; l++) unit_data_in[l*DW +: DW] = $urandom;
      rsp_ready_out = N'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
